// File: rtl/spike_train_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_train_decoder
//  Purpose  : Reader for the neuron membrane-voltage bus. Detects spikes with
//             hysteresis, measures inter-spike intervals, flags bursts and
//             queues {first, burst, isi} records over valid/ready.
//  Options  : SPIKE_RATE_WINDOW_EN - adds per-window spike-rate reporting on
//             rate_out/rate_valid; when undefined both outputs are tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module spike_train_decoder #(
  parameter logic signed [7:0] V_THRESH   = 8'sh13,
  parameter logic signed [7:0] V_REARM    = 8'shE0,
  parameter int                ISI_W      = 16,
  parameter int                BURST_ISI  = 64,
  parameter int                FIFO_DEPTH = 4,
  parameter int                WIN_LEN    = 4096,
  parameter int                CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic signed [7:0]       v_in,
  input  logic                    clear,
  output logic                    spike,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ISI_W+1:0]        evt_data,
  output logic                    overflow,
  output logic                    burst_active,
  output logic [CNT_W-1:0]        rate_out,
  output logic                    rate_valid
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_REFRACT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             detect;
  logic             first;
  logic             burst;
  logic [ISI_W-1:0] isi_cnt;
  logic             prev_burst;
  logic [ISI_W+1:0] evt_rec;

  logic [ISI_W+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             push_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: clear wins over ena; ena=0 holds the state
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = S_IDLE;
    end else if (ena) begin
      case (state)
        S_IDLE, S_ARMED: if (v_in >= V_THRESH) next_state = S_REFRACT;
        S_REFRACT:       if (v_in <= V_REARM)  next_state = S_ARMED;
        default:         next_state = S_IDLE;
      endcase
    end
  end

  // Output decode: a spike is the first qualifying sample while not refractory
  always_comb begin
    detect = 1'b0;
    if (!clear && ena && (state == S_IDLE || state == S_ARMED) && (v_in >= V_THRESH))
      detect = 1'b1;
  end

  // IDLE is only occupied before the first spike since reset/clear
  assign first   = (state == S_IDLE);
  assign burst   = !first && (isi_cnt <= ISI_W'(BURST_ISI));
  assign evt_rec = {first, burst, first ? {ISI_W{1'b0}} : isi_cnt};

  // Spike pulse, ISI counter and burst tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike        <= 1'b0;
      isi_cnt      <= '0;
      prev_burst   <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      spike <= detect;
      if (clear) begin
        isi_cnt      <= '0;
        prev_burst   <= 1'b0;
        burst_active <= 1'b0;
      end else if (ena) begin
        // The detecting sample is interval 1 of the next ISI
        if (detect)              isi_cnt <= ISI_W'(1);
        else if (isi_cnt != '1)  isi_cnt <= isi_cnt + 1'b1;
        if (detect) begin
          prev_burst   <= burst;
          burst_active <= burst && prev_burst;
        end
      end
    end
  end

  assign full      = (count == FIFO_FULL_CNT);
  assign evt_valid = (count != '0);
  assign evt_data  = mem[rd_ptr];
  assign pop       = evt_valid && evt_ready;
  // A pop in the same cycle frees the slot the push needs
  assign push_ok   = detect && (!full || pop);

  // Event FIFO storage, pointers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= evt_rec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (detect && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef SPIKE_RATE_WINDOW_EN
  localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] spk_next;

  // Spike count including the current sample, saturating
  assign spk_next = (detect && spk_cnt != '1) ? spk_cnt + 1'b1 : spk_cnt;

  // Window sample counter; publishes the count on the last sample of a window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      spk_cnt    <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (clear) begin
        win_cnt <= '0;
        spk_cnt <= '0;
      end else if (ena) begin
        if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
          rate_out   <= spk_next;
          rate_valid <= 1'b1;
          win_cnt    <= '0;
          spk_cnt    <= '0;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          spk_cnt <= spk_next;
        end
      end
    end
  end
`else
  assign rate_out   = '0;
  assign rate_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_train_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spike_train_decoder
//  Purpose  : Directed self-checking bench for spike_train_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spike_train_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  v_in = 8'h00;
  logic        clear = 1'b0;
  logic        evt_ready = 1'b0;
  logic        spike;
  logic        evt_valid;
  logic [17:0] evt_data;
  logic        overflow;
  logic        burst_active;
  logic [7:0]  rate_out;
  logic        rate_valid;

  int checks = 0;
  int failures = 0;
  int nspk = 0;

  spike_train_decoder #(.WIN_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .v_in(v_in), .clear(clear),
    .spike(spike), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .overflow(overflow), .burst_active(burst_active),
    .rate_out(rate_out), .rate_valid(rate_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given sample; outputs observed 1 time unit after the edge
  task automatic step(input logic e, input logic [7:0] v);
    ena = e;
    v_in = v;
    @(posedge clk);
    #1;
    if (spike) nspk++;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    ena = 1'b1;
    v_in = 8'h13;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_no_spike", {31'd0, spike}, 32'd0);
    check("clear_empty", {31'd0, evt_valid}, 32'd0);
  endtask

  // Rearm, 98 quiet samples, then threshold: an ISI of exactly 100
  task automatic spike_isi100();
    step(1'b1, 8'hE0);
    for (int i = 0; i < 98; i++) step(1'b1, 8'h00);
    step(1'b1, 8'h13);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    check("rst_spike", {31'd0, spike}, 32'd0);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_data", {14'd0, evt_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_rate", {24'd0, rate_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hysteresis and ISI
    evt_ready = 1'b1;
    nspk = 0;
    step(1'b1, 8'h13);
    check("first_spike", {31'd0, spike}, 32'd1);
    check("first_valid", {31'd0, evt_valid}, 32'd1);
    check("first_rec", {14'd0, evt_data}, 32'h20000);
    step(1'b1, 8'hE0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'h00);
    step(1'b1, 8'h14);
    check("isi11_rec", {14'd0, evt_data}, 32'h1000B);
    check("hyst_spikes", nspk, 2);
    check("ba_after_first", {31'd0, burst_active}, 32'd0);

    // Re-arm gating
    do_clear();
    nspk = 0;
    step(1'b1, 8'h13);
    check("clr_first_rec", {14'd0, evt_data}, 32'h20000);
    step(1'b1, 8'h00);
    step(1'b1, 8'h13);
    check("gate_spikes", nspk, 1);

    // Two consecutive burst intervals
    step(1'b1, 8'hE0);
    step(1'b1, 8'h13);
    check("ba_one_burst", {31'd0, burst_active}, 32'd0);
    step(1'b1, 8'hE0);
    step(1'b1, 8'h13);
    check("ba_two_burst", {31'd0, burst_active}, 32'd1);
    check("isi2_rec", {14'd0, evt_data}, 32'h10002);
    step(1'b0, 8'h00);
    check("drained", {31'd0, evt_valid}, 32'd0);

    // FIFO full and overflow
    evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) spike_isi100();
    check("full_no_ovf", {31'd0, overflow}, 32'd0);
    spike_isi100();
    check("ovf_set", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", {31'd0, evt_valid}, 32'd1);
      check("drain_rec", {14'd0, evt_data}, 32'h00064);
      evt_ready = 1'b1;
      step(1'b0, 8'h00);
      evt_ready = 1'b0;
    end
    check("drain_empty", {31'd0, evt_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Full push with simultaneous pop
    do_clear();
    check("clear_ovf", {31'd0, overflow}, 32'd0);
    step(1'b1, 8'h13);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'hE0);
      step(1'b1, 8'h13);
    end
    step(1'b1, 8'hE0);
    evt_ready = 1'b1;
    step(1'b1, 8'h13);
    evt_ready = 1'b0;
    check("pushpop_ovf", {31'd0, overflow}, 32'd0);
    check("pushpop_head", {14'd0, evt_data}, 32'h10002);
    n = 0;
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (evt_valid) n++;
      step(1'b0, 8'h00);
    end
    check("pushpop_count", n, 4);

    // Reset mid-burst with a record pending and the detector refractory
    evt_ready = 1'b0;
    step(1'b1, 8'hE0);
    step(1'b1, 8'h13);
    check("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, evt_valid}, 32'd0);
    check("async_spike", {31'd0, spike}, 32'd0);
    check("async_data", {14'd0, evt_data}, 32'd0);
    check("async_ba", {31'd0, burst_active}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h13);
    check("post_rst_spike", {31'd0, spike}, 32'd1);
    check("post_rst_rec", {14'd0, evt_data}, 32'h20000);

    // ena=0 freezes the detector: a masked rearm sample must not re-arm
    step(1'b0, 8'hE0);
    step(1'b1, 8'h13);
    check("ena_freeze", {31'd0, spike}, 32'd0);

    // Rate window (WIN_LEN=32): spikes at samples 8,16,24,32
    do_clear();
    for (int s = 1; s <= 32; s++) begin
      step(1'b1, (s % 8 == 0) ? 8'h13 : 8'hE0);
      if (s == 31) check("rate_valid_early", {31'd0, rate_valid}, 32'd0);
    end
`ifdef SPIKE_RATE_WINDOW_EN
    check("rate_valid_w1", {31'd0, rate_valid}, 32'd1);
    check("rate_out_w1", {24'd0, rate_out}, 32'd4);
`else
    check("rate_valid_off", {31'd0, rate_valid}, 32'd0);
    check("rate_out_off", {24'd0, rate_out}, 32'd0);
`endif
    step(1'b1, 8'h00);
    check("rate_valid_pulse", {31'd0, rate_valid}, 32'd0);
    for (int s = 2; s <= 32; s++) step(1'b1, 8'h00);
`ifdef SPIKE_RATE_WINDOW_EN
    check("rate_valid_w2", {31'd0, rate_valid}, 32'd1);
`else
    check("rate_valid_w2", {31'd0, rate_valid}, 32'd0);
`endif
    check("rate_out_w2", {24'd0, rate_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_train_decoder.md
Name: spike_train_decoder

Overview:
- Reader side of the neuron membrane-voltage output bus.
- Samples the 8-bit signed membrane voltage (1 sign, 1 integer, 6 fraction bits; 0x13 is about 0.3, the spike peak).
- Detects spikes with hysteresis, measures inter-spike interval (ISI) in samples, and flags bursts.
- Queues ISI event records to a downstream consumer over valid/ready, and optionally reports spike rate per fixed window.

Parameters:
- V_THRESH, 8'sh13, signed spike threshold; spike when v_in >= V_THRESH.
- V_REARM, 8'shE0 (-0.5), signed re-arm level; detector re-arms when v_in <= V_REARM.
- ISI_W, 16, ISI counter/record width.
- BURST_ISI, 64, ISI (in samples) at or below which an interval is a burst interval.
- FIFO_DEPTH, 4, event queue depth (power of 2, >= 2).
- WIN_LEN, 4096, rate window length in samples.
- CNT_W, 8, rate count width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, sample strobe; v_in is valid this cycle.
- v_in, input, 8, signed membrane voltage sample.
- clear, input, 1, synchronous soft clear.
- spike, output, 1, one-cycle pulse per detected spike.
- evt_valid, output, 1, event record available.
- evt_ready, input, 1, consumer accepts the record.
- evt_data, output, ISI_W+2, {first, burst, isi[ISI_W-1:0]}.
- overflow, output, 1, sticky: an event was dropped.
- burst_active, output, 1, the last two ISIs were both burst intervals.
- rate_out, output, CNT_W, spike count of the last completed window.
- rate_valid, output, 1, one-cycle pulse when rate_out updates.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, clock port clk, reset port rst_n.
- Reset values: every output and every internal register is 0; state is IDLE; FIFO is empty.
- FSM states:
  - IDLE: no spike seen yet.
  - ARMED: prior spike exists, waiting for the next one.
  - REFRACT: above threshold, waiting for the re-arm level.
- Transitions (ena=1 only; ena=0 freezes all state and counters):
  - IDLE or ARMED with v_in >= V_THRESH: detect a spike, go to REFRACT.
  - REFRACT with v_in <= V_REARM: go to ARMED.
  - All other cases: hold the current state.
- Spike detection timing:
  - spike is a registered output, high the cycle after the detecting sample.
  - The detecting sample is the 1st ena-sample to meet threshold; there is no second spike until re-arm.
- ISI counter:
  - Increments on each ena sample; saturates at 2^ISI_W-1.
  - Loaded with 1 on a detecting sample, i.e. it counts that sample as interval 1 of the next ISI.
  - The ISI recorded for a spike is the counter value before the load.
- Event record: pushed on the detecting sample.
  - first = 1 only for the first spike after reset or clear; isi = 0 when first = 1.
  - burst = !first && isi <= BURST_ISI.
- burst_active: updated per event as the burst bit of the current event AND the burst bit of the previous event; cleared by a first event.
- FIFO behaviour:
  - evt_valid = !empty; evt_data is the head record, stable while evt_valid && !evt_ready.
  - A pop occurs on evt_valid && evt_ready.
  - Push when full with no same-cycle pop: record dropped, overflow set (sticky).
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push into an empty FIFO: evt_valid is high the next cycle (latency 1).
- clear (synchronous, has priority over ena):
  - Returns the FSM to IDLE and empties the FIFO.
  - Zeroes the ISI counter, overflow, burst_active and the window counters.
  - Does not pulse spike or rate_valid.
- Signed compares only; v_in = 8'h80 is -2.0, below V_REARM.

Optional Feature:
- Macro: SPIKE_RATE_WINDOW_EN.
- Defined:
  - Window counter counts ena samples 1..WIN_LEN.
  - On the WIN_LEN-th sample, rate_out takes the window spike count (saturating at 2^CNT_W-1) and rate_valid pulses for one cycle.
  - The count restarts at 0.
  - A spike detected on the window-end sample counts in the ending window.
- Undefined: rate_out and rate_valid are tied to 0, and no window logic is present.

Test Plan:
- Reset mid-burst:
  - Stimulus: assert rst_n=0 while evt_valid=1 and state is REFRACT.
  - Required response: all outputs 0 immediately (asynchronous).
  - Then, with ena=1 and v_in=0x13, spike is high 1 cycle later and evt_data={1,0,0}.
- Hysteresis and ISI:
  - Stimulus: v_in pattern 0x13, 0xE0, nine samples of 0x00, then 0x14 (ena always 1); evt_ready=1.
  - Required response: exactly 2 spikes; second record = {0,1,11}.
- Re-arm gating: v_in = 0x13, 0x00, 0x13 (no sample <= 0xE0) -> only one spike.
- FIFO full and overflow:
  - Stimulus: evt_ready=0; generate 5 spikes 100 samples apart.
  - Required response: 4 records held; overflow=1.
  - Then evt_ready=1 drains 4 records in order, each isi=100, burst=0.
- Full push with simultaneous pop: FIFO full, spike and pop in the same cycle -> count stays 4, overflow stays 0.
- Rate window (SPIKE_RATE_WINDOW_EN, WIN_LEN=32):
  - Stimulus: spikes detected at samples 8, 16, 24, 32.
  - Required response: rate_out=4 with rate_valid pulsing 1 cycle after sample 32.
  - Next window with no spikes: rate_out=0.
